// File: rtl/rs_alloc_pkg.sv
// Shared definitions for the reservation-station allocator.
// Holds the station class codes, the station numbering map and a popcount helper.
package rs_alloc_pkg;

  localparam int RS_STN_W = 5;

  // Station class codes. Code 0 and codes 5..7 are not valid classes.
  typedef enum logic [2:0] {
    ST_NONE = 3'd0,
    ADDST   = 3'd1,
    MULST   = 3'd2,
    MEMLST  = 3'd3,
    MEMSST  = 3'd4
  } st_type_e;

  // Station numbering: 0 is never allocated, so a zero stn never aliases a real station.
  localparam int RS_ADD_BASE = 1;
  localparam int RS_MUL_BASE = 9;
  localparam int RS_LD_BASE  = 17;
  localparam int RS_ST_BASE  = 21;

  localparam logic [RS_STN_W-1:0] ADD0 = RS_STN_W'(RS_ADD_BASE);
  localparam logic [RS_STN_W-1:0] MUL0 = RS_STN_W'(RS_MUL_BASE);
  localparam logic [RS_STN_W-1:0] LD0  = RS_STN_W'(RS_LD_BASE);
  localparam logic [RS_STN_W-1:0] ST0  = RS_STN_W'(RS_ST_BASE);

  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] c;
    c = '0;
    for (int i = 0; i < 8; i++) c = c + {3'b000, v[i]};
    return c;
  endfunction

endpackage

// File: rtl/rs_alloc_if.sv
// Issue/release port bundle of the reservation-station allocator.
interface rs_alloc_if
  import rs_alloc_pkg::*;
#(
    parameter int STN_W = RS_STN_W,
    parameter int N_ADD = 3,
    parameter int N_MUL = 3,
    parameter int N_LD  = 1,
    parameter int N_ST  = 1
);
    // Handshake: ins_valid is the request and !ins_stall is the ready; an instruction
    // is taken on a rising edge where ins_valid=1 and ins_stall=0, and it is reported
    // one cycle later by a single-cycle issue pulse carrying its station number.
    logic             ins_valid;
    logic [2:0]       st_type;
    logic             waw;
    logic             flush;
    logic             rel_valid;
    logic [STN_W-1:0] rel_stn;

    logic             issue;
    logic [STN_W-1:0] stn;
    logic             ins_stall;
    logic [N_ADD-1:0] busy_add;
    logic [N_MUL-1:0] busy_mul;
    logic [N_LD-1:0]  busy_ld;
    logic [N_ST-1:0]  busy_st;
    logic [3:0]       cnt_add;
    logic [3:0]       cnt_mul;

    modport master (
        output ins_valid, st_type, waw, flush, rel_valid, rel_stn,
        input  issue, stn, ins_stall, busy_add, busy_mul, busy_ld, busy_st, cnt_add, cnt_mul
    );

    modport slave (
        input  ins_valid, st_type, waw, flush, rel_valid, rel_stn,
        output issue, stn, ins_stall, busy_add, busy_mul, busy_ld, busy_st, cnt_add, cnt_mul
    );

endinterface

// File: rtl/rs_alloc_pick.sv
// Free-station picker for one class: highest free index, or first free index
// at or above the round-robin pointer (wrapping) when RR is set.
module rs_pick #(
    parameter int N  = 3,
    parameter bit RR = 1'b0,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  free,
    input  logic [IW-1:0] ptr,
    output logic          found,
    output logic [IW-1:0] idx
);

    int j;

    always_comb begin
        found = |free;
        idx   = '0;
        j     = 0;
        if (!RR) begin
            for (int i = 0; i < N; i++) begin
                if (free[IW'(i)]) idx = IW'(i);
            end
        end else begin
            // Walk offsets from far to near so the nearest free slot is written last.
            for (int k = N - 1; k >= 0; k--) begin
                j = (int'(ptr) + k) % N;
                if (free[IW'(j)]) idx = IW'(j);
            end
        end
    end

endmodule

// File: rtl/rs_alloc.sv
// Reservation-station allocator: picks a free station of the decoded class,
// tracks per-class occupancy and frees stations on release strobes.
module rs_alloc
  import rs_alloc_pkg::*;
#(
    parameter int N_ADD    = 3,
    parameter int N_MUL    = 3,
    parameter int N_LD     = 1,
    parameter int N_ST     = 1,
    parameter bit RR       = 1'b0,
    parameter int STN_W    = RS_STN_W,
    parameter int ADD_BASE = RS_ADD_BASE,
    parameter int MUL_BASE = RS_MUL_BASE,
    parameter int LD_BASE  = RS_LD_BASE,
    parameter int ST_BASE  = RS_ST_BASE
) (
    input logic       clk,
    input logic       rst,
    rs_alloc_if.slave bus
);

    localparam int AW = (N_ADD > 1) ? $clog2(N_ADD) : 1;
    localparam int MW = (N_MUL > 1) ? $clog2(N_MUL) : 1;
    localparam int LW = (N_LD  > 1) ? $clog2(N_LD)  : 1;
    localparam int SW = (N_ST  > 1) ? $clog2(N_ST)  : 1;

    logic [N_ADD-1:0] add_busy_q, add_busy_d, add_rel, add_alloc;
    logic [N_MUL-1:0] mul_busy_q, mul_busy_d, mul_rel, mul_alloc;
    logic [N_LD-1:0]  ld_busy_q,  ld_busy_d,  ld_rel,  ld_alloc;
    logic [N_ST-1:0]  st_busy_q,  st_busy_d,  st_rel,  st_alloc;

    logic [AW-1:0] add_ptr_q, add_ptr_d, add_idx;
    logic [MW-1:0] mul_ptr_q, mul_ptr_d, mul_idx;
    logic [LW-1:0] ld_ptr_q,  ld_ptr_d,  ld_idx;
    logic [SW-1:0] st_ptr_q,  st_ptr_d,  st_idx;
    logic          add_found, mul_found, ld_found, st_found;

    logic             issue_q, issue_d;
    logic [STN_W-1:0] stn_q, stn_d;
    logic [3:0]       cnt_add_q, cnt_add_d, cnt_mul_q, cnt_mul_d;
    logic             cls_found, accept;
    logic [STN_W-1:0] sel_stn;

    // Pickers see the current bitmap only, so a station released this cycle is never reused this cycle.
    rs_pick #(.N(N_ADD), .RR(RR)) u_pick_add (.free(~add_busy_q), .ptr(add_ptr_q), .found(add_found), .idx(add_idx));
    rs_pick #(.N(N_MUL), .RR(RR)) u_pick_mul (.free(~mul_busy_q), .ptr(mul_ptr_q), .found(mul_found), .idx(mul_idx));
    rs_pick #(.N(N_LD),  .RR(RR)) u_pick_ld  (.free(~ld_busy_q),  .ptr(ld_ptr_q),  .found(ld_found),  .idx(ld_idx));
    rs_pick #(.N(N_ST),  .RR(RR)) u_pick_st  (.free(~st_busy_q),  .ptr(st_ptr_q),  .found(st_found),  .idx(st_idx));

    always_comb begin
        cls_found = 1'b0;
        sel_stn   = '0;
        case (bus.st_type)
            ADDST:   begin cls_found = add_found; sel_stn = STN_W'(ADD_BASE) + STN_W'(add_idx); end
            MULST:   begin cls_found = mul_found; sel_stn = STN_W'(MUL_BASE) + STN_W'(mul_idx); end
            MEMLST:  begin cls_found = ld_found;  sel_stn = STN_W'(LD_BASE)  + STN_W'(ld_idx);  end
            MEMSST:  begin cls_found = st_found;  sel_stn = STN_W'(ST_BASE)  + STN_W'(st_idx);  end
            default: begin cls_found = 1'b0;      sel_stn = '0;                                 end
        endcase
        accept = bus.ins_valid & ~bus.waw & ~bus.flush & cls_found;
    end

    always_comb begin
        add_rel = '0;
        mul_rel = '0;
        ld_rel  = '0;
        st_rel  = '0;
        for (int i = 0; i < N_ADD; i++) if (bus.rel_valid && int'(bus.rel_stn) == ADD_BASE + i) add_rel[i] = 1'b1;
        for (int i = 0; i < N_MUL; i++) if (bus.rel_valid && int'(bus.rel_stn) == MUL_BASE + i) mul_rel[i] = 1'b1;
        for (int i = 0; i < N_LD;  i++) if (bus.rel_valid && int'(bus.rel_stn) == LD_BASE  + i) ld_rel[i]  = 1'b1;
        for (int i = 0; i < N_ST;  i++) if (bus.rel_valid && int'(bus.rel_stn) == ST_BASE  + i) st_rel[i]  = 1'b1;
    end

    always_comb begin
        add_alloc = '0;
        mul_alloc = '0;
        ld_alloc  = '0;
        st_alloc  = '0;
        if (accept) begin
            case (bus.st_type)
                ADDST:   add_alloc[add_idx] = 1'b1;
                MULST:   mul_alloc[mul_idx] = 1'b1;
                MEMLST:  ld_alloc[ld_idx]   = 1'b1;
                MEMSST:  st_alloc[st_idx]   = 1'b1;
                default: ;
            endcase
        end
    end

    always_comb begin
        add_busy_d = bus.flush ? '0 : ((add_busy_q & ~add_rel) | add_alloc);
        mul_busy_d = bus.flush ? '0 : ((mul_busy_q & ~mul_rel) | mul_alloc);
        ld_busy_d  = bus.flush ? '0 : ((ld_busy_q  & ~ld_rel)  | ld_alloc);
        st_busy_d  = bus.flush ? '0 : ((st_busy_q  & ~st_rel)  | st_alloc);

        add_ptr_d = add_ptr_q;
        mul_ptr_d = mul_ptr_q;
        ld_ptr_d  = ld_ptr_q;
        st_ptr_d  = st_ptr_q;
        if (bus.flush) begin
            add_ptr_d = '0;
            mul_ptr_d = '0;
            ld_ptr_d  = '0;
            st_ptr_d  = '0;
        end else begin
            if (|add_alloc) add_ptr_d = (int'(add_idx) == N_ADD - 1) ? '0 : add_idx + AW'(1);
            if (|mul_alloc) mul_ptr_d = (int'(mul_idx) == N_MUL - 1) ? '0 : mul_idx + MW'(1);
            if (|ld_alloc)  ld_ptr_d  = (int'(ld_idx)  == N_LD  - 1) ? '0 : ld_idx  + LW'(1);
            if (|st_alloc)  st_ptr_d  = (int'(st_idx)  == N_ST  - 1) ? '0 : st_idx  + SW'(1);
        end

        // Counts follow the next bitmap so they can never drift from it.
        cnt_add_d = popcount8(8'(add_busy_d));
        cnt_mul_d = popcount8(8'(mul_busy_d));
        issue_d   = accept;
        stn_d     = accept ? sel_stn : stn_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            add_busy_q <= '0;
            mul_busy_q <= '0;
            ld_busy_q  <= '0;
            st_busy_q  <= '0;
            add_ptr_q  <= '0;
            mul_ptr_q  <= '0;
            ld_ptr_q   <= '0;
            st_ptr_q   <= '0;
            cnt_add_q  <= '0;
            cnt_mul_q  <= '0;
            issue_q    <= 1'b0;
            stn_q      <= '0;
        end else begin
            add_busy_q <= add_busy_d;
            mul_busy_q <= mul_busy_d;
            ld_busy_q  <= ld_busy_d;
            st_busy_q  <= st_busy_d;
            add_ptr_q  <= add_ptr_d;
            mul_ptr_q  <= mul_ptr_d;
            ld_ptr_q   <= ld_ptr_d;
            st_ptr_q   <= st_ptr_d;
            cnt_add_q  <= cnt_add_d;
            cnt_mul_q  <= cnt_mul_d;
            issue_q    <= issue_d;
            stn_q      <= stn_d;
        end
    end

    assign bus.ins_stall = bus.ins_valid & ~accept;
    assign bus.issue     = issue_q;
    assign bus.stn       = stn_q;
    assign bus.busy_add  = add_busy_q;
    assign bus.busy_mul  = mul_busy_q;
    assign bus.busy_ld   = ld_busy_q;
    assign bus.busy_st   = st_busy_q;
    assign bus.cnt_add   = cnt_add_q;
    assign bus.cnt_mul   = cnt_mul_q;

endmodule

// File: tb/tb_rs_alloc.sv
// Bench for rs_alloc: directed scenarios plus randomized traffic against a
// station-occupancy model; a fixed-priority instance and a round-robin instance.
module tb_rs_alloc;
    import rs_alloc_pkg::*;

    localparam int W = RS_STN_W;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    rs_alloc_if #(.STN_W(W), .N_ADD(3), .N_MUL(3), .N_LD(1), .N_ST(1)) if0 ();
    rs_alloc_if #(.STN_W(W), .N_ADD(3), .N_MUL(3), .N_LD(1), .N_ST(1)) if1 ();

    rs_alloc #(.N_ADD(3), .N_MUL(3), .N_LD(1), .N_ST(1), .RR(1'b0)) dut0 (.clk(clk), .rst(rst), .bus(if0.slave));
    rs_alloc #(.N_ADD(3), .N_MUL(3), .N_LD(1), .N_ST(1), .RR(1'b1)) dut1 (.clk(clk), .rst(rst), .bus(if1.slave));

    // Occupancy model: class 0 add, 1 mul, 2 load, 3 store.
    int         m_n[4]    = '{3, 3, 1, 1};
    int         m_base[4] = '{RS_ADD_BASE, RS_MUL_BASE, RS_LD_BASE, RS_ST_BASE};
    bit [7:0]   m_busy[4];
    logic       exp_issue, exp_stall, obs_stall, obs_stall1;
    logic [W-1:0] exp_stn;
    logic [W-1:0] exp_q[$];

    function automatic int m_class(input logic [2:0] t);
        case (t)
            ADDST:   return 0;
            MULST:   return 1;
            MEMLST:  return 2;
            MEMSST:  return 3;
            default: return -1;
        endcase
    endfunction

    function automatic int m_pick(input int c);
        for (int i = m_n[c] - 1; i >= 0; i--) if (!m_busy[c][i]) return i;
        return -1;
    endfunction

    task automatic m_clear();
        for (int c = 0; c < 4; c++) m_busy[c] = '0;
    endtask

    task automatic idle0();
        if0.ins_valid = 0; if0.st_type = 0; if0.waw = 0; if0.flush = 0; if0.rel_valid = 0; if0.rel_stn = 0;
    endtask

    task automatic idle1();
        if1.ins_valid = 0; if1.st_type = 0; if1.waw = 0; if1.flush = 0; if1.rel_valid = 0; if1.rel_stn = 0;
    endtask

    // One cycle on the fixed-priority instance; the model is advanced alongside.
    task automatic step0(input logic v, input logic [2:0] t, input logic w, input logic f,
                         input logic rv, input logic [W-1:0] rs);
        int c, p;
        bit acc;
        @(negedge clk);
        if0.ins_valid = v; if0.st_type = t; if0.waw = w; if0.flush = f; if0.rel_valid = rv; if0.rel_stn = rs;
        #1 obs_stall = if0.ins_stall;
        c = m_class(t);
        p = (c >= 0) ? m_pick(c) : -1;
        acc = v && !w && !f && (p >= 0);
        exp_stall = v && !acc;
        @(posedge clk);
        #1;
        if (f) m_clear();
        else begin
            for (int cc = 0; cc < 4; cc++)
                for (int i = 0; i < m_n[cc]; i++)
                    if (rv && int'(rs) == m_base[cc] + i) m_busy[cc][i] = 1'b0;
            if (acc) m_busy[c][p] = 1'b1;
        end
        exp_issue = acc;
        if (acc) exp_stn = W'(m_base[c] + p);
        idle0();
    endtask

    task automatic step1(input logic v, input logic [2:0] t, input logic rv, input logic [W-1:0] rs);
        @(negedge clk);
        if1.ins_valid = v; if1.st_type = t; if1.rel_valid = rv; if1.rel_stn = rs;
        #1 obs_stall1 = if1.ins_stall;
        @(posedge clk);
        #1;
        idle1();
    endtask

    task automatic test_reset();
        #12;
        checks++; if (if0.issue !== 1'b0) begin errors++; $display("FAIL reset_issue got %b want 0", if0.issue); end
        checks++; if (if0.stn !== '0) begin errors++; $display("FAIL reset_stn got %0d want 0", if0.stn); end
        checks++; if (if0.busy_add !== 3'b000 || if0.busy_mul !== 3'b000 || if0.busy_ld !== 1'b0 || if0.busy_st !== 1'b0)
            begin errors++; $display("FAIL reset_busy got %b %b %b %b want zeros", if0.busy_add, if0.busy_mul, if0.busy_ld, if0.busy_st); end
        checks++; if (if0.cnt_add !== 4'd0 || if0.cnt_mul !== 4'd0) begin errors++; $display("FAIL reset_cnt got %0d %0d want 0 0", if0.cnt_add, if0.cnt_mul); end
        checks++; if (if1.issue !== 1'b0 || if1.stn !== '0) begin errors++; $display("FAIL reset_rr got %b %0d want 0 0", if1.issue, if1.stn); end
        @(negedge clk);
        rst = 1'b0;
        m_clear();
    endtask

    task automatic test_fill_add();
        logic [W-1:0] e;
        for (int k = 0; k < 3; k++) begin
            step0(1, ADDST, 0, 0, 0, '0);
            e = W'(RS_ADD_BASE + 2 - k);
            checks++; if (obs_stall !== 1'b0) begin errors++; $display("FAIL fill_stall%0d got %b want 0", k, obs_stall); end
            checks++; if (if0.issue !== 1'b1 || if0.stn !== e) begin errors++; $display("FAIL fill_stn%0d got %b/%0d want 1/%0d", k, if0.issue, if0.stn, e); end
        end
        step0(1, ADDST, 0, 0, 0, '0);
        checks++; if (obs_stall !== 1'b1) begin errors++; $display("FAIL fill_full_stall got %b want 1", obs_stall); end
        checks++; if (if0.issue !== 1'b0) begin errors++; $display("FAIL fill_full_issue got %b want 0", if0.issue); end
        checks++; if (if0.cnt_add !== 4'd3 || if0.busy_add !== 3'b111) begin errors++; $display("FAIL fill_full_cnt got %0d/%b want 3/111", if0.cnt_add, if0.busy_add); end
    endtask

    task automatic test_release_alloc();
        step0(1, ADDST, 0, 0, 1, W'(RS_ADD_BASE + 1));
        checks++; if (obs_stall !== 1'b1 || if0.issue !== 1'b0) begin errors++; $display("FAIL relalloc_nobypass got stall %b issue %b want 1 0", obs_stall, if0.issue); end
        checks++; if (if0.busy_add !== 3'b101 || if0.cnt_add !== 4'd2) begin errors++; $display("FAIL relalloc_busy got %b/%0d want 101/2", if0.busy_add, if0.cnt_add); end
        step0(1, ADDST, 0, 0, 0, '0);
        checks++; if (obs_stall !== 1'b0 || if0.issue !== 1'b1 || if0.stn !== W'(RS_ADD_BASE + 1))
            begin errors++; $display("FAIL relalloc_reuse got stall %b issue %b stn %0d want 0 1 %0d", obs_stall, if0.issue, if0.stn, RS_ADD_BASE + 1); end
    endtask

    task automatic test_waw();
        step0(0, ST_NONE, 0, 1, 0, '0);
        checks++; if (if0.busy_add !== 3'b000 || if0.cnt_add !== 4'd0) begin errors++; $display("FAIL flush_clear got %b/%0d want 000/0", if0.busy_add, if0.cnt_add); end
        step0(1, ADDST, 1, 0, 0, '0);
        checks++; if (obs_stall !== 1'b1 || if0.issue !== 1'b0 || if0.busy_add !== 3'b000)
            begin errors++; $display("FAIL waw_block got stall %b issue %b busy %b want 1 0 000", obs_stall, if0.issue, if0.busy_add); end
        step0(1, ADDST, 0, 0, 0, '0);
        checks++; if (if0.issue !== 1'b1 || if0.stn !== W'(RS_ADD_BASE + 2)) begin errors++; $display("FAIL waw_release got %b/%0d want 1/%0d", if0.issue, if0.stn, RS_ADD_BASE + 2); end
        step0(1, 3'd6, 0, 0, 0, '0);
        checks++; if (obs_stall !== 1'b1 || if0.issue !== 1'b0) begin errors++; $display("FAIL bad_class got stall %b issue %b want 1 0", obs_stall, if0.issue); end
    endtask

    task automatic test_mem();
        step0(0, ST_NONE, 0, 1, 0, '0);
        step0(1, MEMLST, 0, 0, 0, '0);
        checks++; if (if0.issue !== 1'b1 || if0.stn !== W'(RS_LD_BASE)) begin errors++; $display("FAIL mem_ld got %b/%0d want 1/%0d", if0.issue, if0.stn, RS_LD_BASE); end
        step0(1, MEMSST, 0, 0, 0, '0);
        checks++; if (if0.issue !== 1'b1 || if0.stn !== W'(RS_ST_BASE) || if0.busy_st !== 1'b1) begin errors++; $display("FAIL mem_st got %b/%0d want 1/%0d", if0.issue, if0.stn, RS_ST_BASE); end
        step0(1, MEMLST, 0, 0, 0, '0);
        checks++; if (obs_stall !== 1'b1 || if0.issue !== 1'b0) begin errors++; $display("FAIL mem_ld_full got stall %b issue %b want 1 0", obs_stall, if0.issue); end
        step0(1, MEMLST, 0, 0, 1, W'(RS_LD_BASE));
        checks++; if (obs_stall !== 1'b1 || if0.busy_ld !== 1'b0) begin errors++; $display("FAIL mem_ld_rel got stall %b busy %b want 1 0", obs_stall, if0.busy_ld); end
        step0(1, MEMLST, 0, 0, 0, '0);
        checks++; if (if0.issue !== 1'b1 || if0.stn !== W'(RS_LD_BASE)) begin errors++; $display("FAIL mem_ld_again got %b/%0d want 1/%0d", if0.issue, if0.stn, RS_LD_BASE); end
    endtask

    task automatic test_flush_reset();
        step0(0, ST_NONE, 0, 1, 0, '0);
        step0(1, ADDST, 0, 0, 0, '0);
        step0(1, ADDST, 0, 0, 1, W'(RS_ADD_BASE + 2));
        checks++; if (if0.stn !== W'(RS_ADD_BASE + 1) || if0.busy_add !== 3'b010 || if0.cnt_add !== 4'd1)
            begin errors++; $display("FAIL same_class_both got stn %0d busy %b cnt %0d want %0d 010 1", if0.stn, if0.busy_add, if0.cnt_add, RS_ADD_BASE + 1); end
        step0(1, MULST, 0, 0, 0, '0);
        step0(1, MULST, 0, 0, 0, '0);
        step0(0, ST_NONE, 0, 0, 1, W'(RS_MUL_BASE));
        checks++; if (if0.busy_mul !== 3'b110 || if0.cnt_mul !== 4'd2) begin errors++; $display("FAIL rel_free_noop got %b/%0d want 110/2", if0.busy_mul, if0.cnt_mul); end
        step0(0, ST_NONE, 0, 0, 1, W'(30));
        checks++; if (if0.busy_mul !== 3'b110 || if0.busy_add !== 3'b010) begin errors++; $display("FAIL rel_out_of_range got %b %b want 110 010", if0.busy_mul, if0.busy_add); end
        step0(1, ADDST, 0, 1, 1, W'(RS_MUL_BASE + 1));
        checks++; if (obs_stall !== 1'b1 || if0.issue !== 1'b0) begin errors++; $display("FAIL flush_accept got stall %b issue %b want 1 0", obs_stall, if0.issue); end
        checks++; if (if0.busy_add !== 3'b000 || if0.busy_mul !== 3'b000 || if0.cnt_add !== 4'd0 || if0.cnt_mul !== 4'd0)
            begin errors++; $display("FAIL flush_all got %b %b %0d %0d want zeros", if0.busy_add, if0.busy_mul, if0.cnt_add, if0.cnt_mul); end
        step0(1, MULST, 0, 0, 0, '0);
        step0(1, ADDST, 0, 0, 0, '0);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checks++; if (if0.busy_add !== 3'b000 || if0.busy_mul !== 3'b000 || if0.cnt_add !== 4'd0 || if0.cnt_mul !== 4'd0 || if0.issue !== 1'b0)
            begin errors++; $display("FAIL async_reset got %b %b %0d %0d %b want zeros", if0.busy_add, if0.busy_mul, if0.cnt_add, if0.cnt_mul, if0.issue); end
        @(negedge clk);
        rst = 1'b0;
        m_clear();
    endtask

    task automatic test_rr();
        logic [2:0] eb;
        for (int k = 0; k < 4; k++) begin
            step1(1, MULST, 0, '0);
            eb = 3'(1 << (k % 3));
            checks++; if (if1.issue !== 1'b1 || if1.stn !== W'(RS_MUL_BASE + k % 3) || if1.busy_mul !== eb)
                begin errors++; $display("FAIL rr_alloc%0d got %b/%0d/%b want 1/%0d/%b", k, if1.issue, if1.stn, if1.busy_mul, RS_MUL_BASE + k % 3, eb); end
            step1(0, ST_NONE, 1, W'(RS_MUL_BASE + k % 3));
            checks++; if (if1.busy_mul !== 3'b000 || if1.cnt_mul !== 4'd0) begin errors++; $display("FAIL rr_release%0d got %b/%0d want 000/0", k, if1.busy_mul, if1.cnt_mul); end
        end
    endtask

    task automatic test_random();
        logic v, w, f, rv;
        logic [2:0] t;
        logic [W-1:0] rs, e;
        bit [7:0] eb;
        int c;
        step0(0, ST_NONE, 0, 1, 0, '0);
        exp_q.delete();
        for (int n = 0; n < 400; n++) begin
            v  = ($urandom_range(0, 3) != 0);
            t  = 3'($urandom_range(0, 5));
            w  = ($urandom_range(0, 9) == 0);
            f  = ($urandom_range(0, 29) == 0);
            rv = ($urandom_range(0, 1) == 1);
            c  = $urandom_range(0, 3);
            rs = ($urandom_range(0, 7) == 0) ? W'($urandom_range(0, 31)) : W'(m_base[c] + $urandom_range(0, m_n[c] - 1));
            step0(v, t, w, f, rv, rs);
            if (exp_issue) exp_q.push_back(exp_stn);
            checks++; if (obs_stall !== exp_stall) begin errors++; $display("FAIL rnd_stall@%0d got %b want %b", n, obs_stall, exp_stall); end
            checks++; if (if0.issue !== exp_issue) begin errors++; $display("FAIL rnd_issue@%0d got %b want %b", n, if0.issue, exp_issue); end
            if (if0.issue === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin errors++; $display("FAIL rnd_stn@%0d got %0d want no issue", n, if0.stn); end
                else begin
                    e = exp_q.pop_front();
                    if (if0.stn !== e) begin errors++; $display("FAIL rnd_stn@%0d got %0d want %0d", n, if0.stn, e); end
                end
            end
            eb = m_busy[0];
            checks++; if (if0.busy_add !== eb[2:0] || if0.cnt_add !== 4'($countones(m_busy[0])))
                begin errors++; $display("FAIL rnd_add@%0d got %b/%0d want %b/%0d", n, if0.busy_add, if0.cnt_add, eb[2:0], $countones(m_busy[0])); end
            eb = m_busy[1];
            checks++; if (if0.busy_mul !== eb[2:0] || if0.cnt_mul !== 4'($countones(m_busy[1])))
                begin errors++; $display("FAIL rnd_mul@%0d got %b/%0d want %b/%0d", n, if0.busy_mul, if0.cnt_mul, eb[2:0], $countones(m_busy[1])); end
            checks++; if (if0.busy_ld !== m_busy[2][0] || if0.busy_st !== m_busy[3][0])
                begin errors++; $display("FAIL rnd_mem@%0d got %b %b want %b %b", n, if0.busy_ld, if0.busy_st, m_busy[2][0], m_busy[3][0]); end
        end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL rnd_pending got %0d want 0", exp_q.size()); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        idle0();
        idle1();
        test_reset();
        test_fill_add();
        test_release_alloc();
        test_waw();
        test_mem();
        test_flush_reset();
        test_rr();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
